// File: rtl/led_bias_seq.sv
// Multi-channel LED bias sequencer.
// Each channel brings up its current reference (nref) first and holds it for a
// settle time before enabling the bias voltage (vref_in). On turn-off it holds
// nref for a discharge time after vref_in drops. Only one channel may be
// settling at a time, which limits inrush on vccio.
//
// Ports:
//   clk       block clock
//   rst_n     asynchronous active-low reset
//   icc40u    global LED power-down, high forces all channels off
//   poc       power-on-clear from the IO ring, high forces all channels off
//   cbit_en   per-channel static configuration enable
//   led_en    per-channel dynamic enable from the LED IP
//   nref      per-channel current-reference enable
//   vref_in   per-channel bias-voltage enable
//   bias_ok   per-channel "bias is up" status
//   settling  some channel is currently settling its reference
module led_bias_seq #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned DISCH_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icc40u,
  input  logic              poc,
  input  logic [NUM_CH-1:0] cbit_en,
  input  logic [NUM_CH-1:0] led_en,
  output logic [NUM_CH-1:0] nref,
  output logic [NUM_CH-1:0] vref_in,
  output logic [NUM_CH-1:0] bias_ok,
  output logic              settling
);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StRefUp = 2'd1,
    StOn    = 2'd2,
    StDisch = 2'd3
  } state_e;

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] DischLoad  = 8'(DISCH_CYC - 1);

  state_e            st_q  [NUM_CH];
  state_e            st_d  [NUM_CH];
  logic [7:0]        cnt_q [NUM_CH];
  logic [7:0]        cnt_d [NUM_CH];

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic              force_off;
  logic              any_refup;
  logic              found;

  logic [NUM_CH-1:0] nref_d;
  logic [NUM_CH-1:0] vref_d;
  logic              settling_d;

  assign req       = cbit_en & led_en;
  assign force_off = icc40u | poc;

  // Arbitration looks at registered state only, so a channel granted this edge
  // blocks everyone else from the next edge onwards.
  always_comb begin
    any_refup = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (st_q[i] == StRefUp) any_refup = 1'b1;
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && st_q[i] == StOff && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (any_refup || force_off) grant = '0;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (force_off) begin
        // Hard power-down: skip discharge entirely.
        st_d[i]  = StOff;
        cnt_d[i] = 8'd0;
      end else begin
        unique case (st_q[i])
          StOff: begin
            if (grant[i]) begin
              st_d[i]  = StRefUp;
              cnt_d[i] = SettleLoad;
            end
          end
          StRefUp: begin
            if (!req[i]) begin
              st_d[i]  = StDisch;
              cnt_d[i] = DischLoad;
            end else if (cnt_q[i] == 8'd0) begin
              st_d[i] = StOn;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          StOn: begin
            if (!req[i]) begin
              st_d[i]  = StDisch;
              cnt_d[i] = DischLoad;
            end
          end
          StDisch: begin
            // req is ignored here; the channel re-arbitrates once back in OFF.
            if (cnt_q[i] == 8'd0) begin
              st_d[i] = StOff;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          default: begin
            st_d[i]  = StOff;
            cnt_d[i] = 8'd0;
          end
        endcase
      end
    end
  end

  // Outputs are flopped alongside the state so they always match st_q.
  always_comb begin
    nref_d     = '0;
    vref_d     = '0;
    settling_d = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      nref_d[i] = (st_d[i] != StOff);
      vref_d[i] = (st_d[i] == StOn);
      if (st_d[i] == StRefUp) settling_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= StOff;
        cnt_q[i] <= 8'd0;
      end
      nref     <= '0;
      vref_in  <= '0;
      bias_ok  <= '0;
      settling <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      nref     <= nref_d;
      vref_in  <= vref_d;
      bias_ok  <= vref_d;
      settling <= settling_d;
    end
  end

endmodule

// File: tb/tb_led_bias_seq.sv
// Bench for led_bias_seq: directed preamble followed by random enables, forces
// and resets. A deadline-based reference model predicts the outputs after
// every edge; a monitor compares them at the following falling edge.
module tb_led_bias_seq;

  localparam int NC   = 2;
  localparam int SC   = 16;
  localparam int DC   = 4;
  localparam int W    = 3 * NC + 1;
  localparam int NCYC = 4000;

  localparam int MOff    = 0;
  localparam int MSettle = 1;
  localparam int MOn     = 2;
  localparam int MDisch  = 3;

  logic          clk;
  logic          rst_n;
  logic          icc40u;
  logic          poc;
  logic [NC-1:0] cbit_en;
  logic [NC-1:0] led_en;
  logic [NC-1:0] nref;
  logic [NC-1:0] vref_in;
  logic [NC-1:0] bias_ok;
  logic          settling;

  led_bias_seq #(
    .NUM_CH    (NC),
    .SETTLE_CYC(SC),
    .DISCH_CYC (DC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .icc40u  (icc40u),
    .poc     (poc),
    .cbit_en (cbit_en),
    .led_en  (led_en),
    .nref    (nref),
    .vref_in (vref_in),
    .bias_ok (bias_ok),
    .settling(settling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];

  // Reference model: each channel has a mode and an absolute edge number at
  // which its current timed phase ends.
  int mode [NC];
  int due  [NC];

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      mode[c] = MOff;
      due[c]  = 0;
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [NC-1:0] n;
    logic [NC-1:0] v;
    logic          s;
    n = '0;
    v = '0;
    s = 1'b0;
    for (int c = 0; c < NC; c++) begin
      n[c] = (mode[c] != MOff);
      v[c] = (mode[c] == MOn);
      if (mode[c] == MSettle) s = 1'b1;
    end
    return {n, v, v, s};
  endfunction

  task automatic model_step(input int k, input logic [NC-1:0] rq, input logic frc);
    int nm [NC];
    bit busy;
    bit granted;
    busy    = 0;
    granted = 0;
    for (int c = 0; c < NC; c++) if (mode[c] == MSettle) busy = 1;
    for (int c = 0; c < NC; c++) begin
      nm[c] = mode[c];
      if (frc) begin
        nm[c] = MOff;
      end else begin
        case (mode[c])
          MOff: if (rq[c] && !busy && !granted) begin
            nm[c]   = MSettle;
            due[c]  = k + SC;
            granted = 1;
          end
          MSettle: begin
            if (!rq[c]) begin
              nm[c]  = MDisch;
              due[c] = k + DC;
            end else if (k == due[c]) begin
              nm[c] = MOn;
            end
          end
          MOn: if (!rq[c]) begin
            nm[c]  = MDisch;
            due[c] = k + DC;
          end
          default: if (k == due[c]) nm[c] = MOff;
        endcase
      end
    end
    for (int c = 0; c < NC; c++) mode[c] = nm[c];
  endtask

  // Inputs for edge n: directed scenarios first, random afterwards.
  task automatic drive(input int n);
    if (n < 240) begin
      cbit_en = (n < 30) ? 2'b01 : 2'b11;
      led_en  = 2'b11;
      if (n >= 60 && n < 62) led_en[0] = 1'b0;  // turn-off, re-request during discharge
      if (n == 106) led_en[0] = 1'b0;           // abort while settling
      icc40u  = (n == 100);
      poc     = (n == 170);
    end else begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 19) == 0) led_en[c] = ~led_en[c];
        if ($urandom_range(0, 99) == 0) cbit_en[c] = ~cbit_en[c];
      end
      icc40u = ($urandom_range(0, 79) == 0);
      poc    = ($urandom_range(0, 79) == 0);
    end
  endtask

  // Monitor: compare whenever an expectation is pending.
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {nref, vref_in, bias_ok, settling};
        checks++;
        if (a !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL outputs t=%0t got {nref,vref,bias,settle}=%b required %b",
                     $time, a, e);
        end
      end
    end
  end

  initial begin
    bit rst_hold;
    rst_hold = 0;
    rst_n    = 1'b0;
    icc40u   = 1'b0;
    poc      = 1'b0;
    cbit_en  = 2'b11;
    led_en   = 2'b11;
    model_clear();
    exp_q.push_back(model_out());  // outputs held at 0 during reset despite requests
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0);

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      if (rst_hold) begin
        model_clear();
        exp_q.push_back(model_out());
        #1 rst_n = 1'b1;
        rst_hold = 0;
      end else if (n == 200 || (n > 240 && $urandom_range(0, 499) == 0)) begin
        // Assert reset between edges; the following falling edge must already see zeros.
        model_clear();
        exp_q.push_back(model_out());
        #1 rst_n = 1'b0;
        rst_hold = 1;
      end else begin
        model_step(n, cbit_en & led_en, icc40u | poc);
        exp_q.push_back(model_out());
        #1;
      end
      drive(n + 1);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
